rom_arbiter: RTL and testbench

- Serves the mapper's PRG ROM and CHR ROM read ports (`promaddr`/`promreq`/`promack`, `cromaddr`/`cromreq`/`cromack`).
- Merges both onto one shared ROM memory port with variable latency.
- Sits between the mapper and the ROM backing store; it is the responder end of the mapper's ROM request interface.
- Arbitrates between the two ports, forwards each access, returns data with a single-cycle ack, and never serves one held request twice.

---
 rtl/rom_arbiter_if.sv | 29 ++
 rtl/rom_arbiter.sv | 123 ++++++++++++
 tb/tb_rom_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_arbiter_if.sv
// Mapper-facing PRG/CHR ROM read ports and the shared ROM memory port.
// The arbiter connects through the slave modport; the mapper/memory side uses master.
interface rom_arbiter_if #(
    parameter int AW = 22
);
    logic [20:0]   promaddr;
    logic          promreq;
    logic [7:0]    promdata;
    logic          promack;
    logic [20:0]   cromaddr;
    logic          cromreq;
    logic [7:0]    cromdata;
    logic          cromack;
    logic [AW-1:0] memaddr;
    logic          memreq;
    logic [7:0]    memrdata;
    logic          memack;
    logic          busy;

    modport master (
        output promaddr, promreq, cromaddr, cromreq, memrdata, memack,
        input  promdata, promack, cromdata, cromack, memaddr, memreq, busy
    );

    modport slave (
        input  promaddr, promreq, cromaddr, cromreq, memrdata, memack,
        output promdata, promack, cromdata, cromack, memaddr, memreq, busy
    );
endinterface

// File: rtl/rom_arbiter.sv
// Merges the PRG and CHR ROM read ports onto one variable-latency memory port.
// Each held request is served once; the done flags block re-service until req drops.
module rom_arbiter #(
    parameter int AW      = 22,
    parameter bit CHRPRIO = 1'b1
) (
    input logic          clk,
    input logic          reset,
    rom_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        PRG_WAIT,
        CHR_WAIT
    } state_t;

    state_t        state, state_d;
    logic          pdone, pdone_d;
    logic          cdone, cdone_d;
    logic          rr_chr, rr_chr_d;
    logic [AW-1:0] memaddr_d;
    logic          memreq_d;
    logic          busy_d;
    logic          promack_d, cromack_d;
    logic [7:0]    promdata_d, cromdata_d;
    logic          ppend, cpend, pick_chr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            pdone        <= 1'b0;
            cdone        <= 1'b0;
            rr_chr       <= 1'b0;
            bus.memaddr  <= '0;
            bus.memreq   <= 1'b0;
            bus.busy     <= 1'b0;
            bus.promack  <= 1'b0;
            bus.cromack  <= 1'b0;
            bus.promdata <= '0;
            bus.cromdata <= '0;
        end else begin
            state        <= state_d;
            pdone        <= pdone_d;
            cdone        <= cdone_d;
            rr_chr       <= rr_chr_d;
            bus.memaddr  <= memaddr_d;
            bus.memreq   <= memreq_d;
            bus.busy     <= busy_d;
            bus.promack  <= promack_d;
            bus.cromack  <= cromack_d;
            bus.promdata <= promdata_d;
            bus.cromdata <= cromdata_d;
        end
    end

    always_comb begin
        state_d    = state;
        rr_chr_d   = rr_chr;
        memaddr_d  = bus.memaddr;
        memreq_d   = bus.memreq;
        busy_d     = bus.busy;
        promack_d  = 1'b0;
        cromack_d  = 1'b0;
        promdata_d = bus.promdata;
        cromdata_d = bus.cromdata;

        ppend = bus.promreq & ~pdone;
        cpend = bus.cromreq & ~cdone;
        if (CHRPRIO) begin
            pick_chr = cpend;
        end else begin
            pick_chr = cpend & (~ppend | rr_chr);
        end

        case (state)
            IDLE: begin
                if (ppend || cpend) begin
                    // Tag bit in the MSB selects the CHR region; any bits between are zero.
                    memaddr_d = '0;
                    if (pick_chr) begin
                        memaddr_d[20:0]   = bus.cromaddr;
                        memaddr_d[AW-1]   = 1'b1;
                        state_d           = CHR_WAIT;
                    end else begin
                        memaddr_d[20:0]   = bus.promaddr;
                        state_d           = PRG_WAIT;
                    end
                    memreq_d = 1'b1;
                    busy_d   = 1'b1;
                    if (!CHRPRIO && ppend && cpend) begin
                        rr_chr_d = ~rr_chr;
                    end
                end
            end
            PRG_WAIT: begin
                if (bus.memack) begin
                    promdata_d = bus.memrdata;
                    promack_d  = 1'b1;
                    memreq_d   = 1'b0;
                    busy_d     = 1'b0;
                    state_d    = IDLE;
                end
            end
            CHR_WAIT: begin
                if (bus.memack) begin
                    cromdata_d = bus.memrdata;
                    cromack_d  = 1'b1;
                    memreq_d   = 1'b0;
                    busy_d     = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Done is set together with the ack so the acked port is already excluded
        // from the arbitration that runs during the ack cycle.
        pdone_d = bus.promreq & (pdone | promack_d);
        cdone_d = bus.cromreq & (cdone | cromack_d);
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// Scoreboard bench for rom_arbiter: two instances (CHR priority and round-robin)
// share one mapper/memory environment selected by sel.
module tb_rom_arbiter;

    typedef struct {
        bit          chr;
        logic [21:0] addr;
        logic [7:0]  data;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        sel;
    logic [20:0] promaddr, cromaddr;
    logic        promreq, cromreq;
    logic [7:0]  memrdata;
    logic        memack;
    logic [7:0]  promdata, cromdata;
    logic        promack, cromack;
    logic [21:0] memaddr;
    logic        memreq, busy;

    rom_arbiter_if #(.AW(22)) bus_p ();
    rom_arbiter_if #(.AW(22)) bus_r ();

    rom_arbiter #(.AW(22), .CHRPRIO(1'b1)) dut_p (.clk(clk), .reset(reset), .bus(bus_p));
    rom_arbiter #(.AW(22), .CHRPRIO(1'b0)) dut_r (.clk(clk), .reset(reset), .bus(bus_r));

    assign bus_p.promaddr = promaddr;
    assign bus_p.cromaddr = cromaddr;
    assign bus_p.promreq  = promreq & ~sel;
    assign bus_p.cromreq  = cromreq & ~sel;
    assign bus_p.memrdata = memrdata;
    assign bus_p.memack   = memack & ~sel;
    assign bus_r.promaddr = promaddr;
    assign bus_r.cromaddr = cromaddr;
    assign bus_r.promreq  = promreq & sel;
    assign bus_r.cromreq  = cromreq & sel;
    assign bus_r.memrdata = memrdata;
    assign bus_r.memack   = memack & sel;

    assign promdata = sel ? bus_r.promdata : bus_p.promdata;
    assign promack  = sel ? bus_r.promack  : bus_p.promack;
    assign cromdata = sel ? bus_r.cromdata : bus_p.cromdata;
    assign cromack  = sel ? bus_r.cromack  : bus_p.cromack;
    assign memaddr  = sel ? bus_r.memaddr  : bus_p.memaddr;
    assign memreq   = sel ? bus_r.memreq   : bus_p.memreq;
    assign busy     = sel ? bus_r.busy     : bus_p.busy;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int unsigned checks = 0;
    int unsigned errors = 0;
    exp_t        exp_q[$];
    logic [20:0] prg_script[$];
    logic [20:0] chr_script[$];
    int unsigned prg_acks = 0, chr_acks = 0, rises = 0;
    int unsigned lat = 3;
    bit          mem_auto = 1'b1;
    bit          man_ack = 1'b0;
    logic [7:0]  man_data = '0;
    logic [21:0] last_addr = '0;
    logic [7:0]  last_prg = '0, last_chr = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
        end
    endtask

    task automatic push_exp(input bit chr, input logic [20:0] a, input logic [7:0] d);
        exp_t e;
        e.chr  = chr;
        e.addr = {chr, a};
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Memory responds lat cycles after memreq rises with data = addr[7:0] ^ 8'hA0.
    task automatic mem_model();
        int unsigned cnt;
        bit          active;
        cnt    = 0;
        active = 1'b0;
        forever begin
            @(negedge clk);
            if (!mem_auto) begin
                active = 1'b0;
                memack = man_ack;
                if (man_ack) memrdata = man_data;
            end else if (memack) begin
                memack = 1'b0;
                active = 1'b0;
            end else if (active) begin
                cnt--;
                if (cnt == 0) begin
                    memack   = 1'b1;
                    memrdata = last_addr[7:0] ^ 8'hA0;
                end
            end else if (memreq) begin
                active    = 1'b1;
                cnt       = lat;
                last_addr = memaddr;
            end
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (promack || cromack) begin
                if (promack) prg_acks++;
                if (cromack) chr_acks++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: promack=%0b cromack=%0b, expected no ack", promack, cromack);
                end else begin
                    e = exp_q.pop_front();
                    chk("ack_port", 32'({cromack, promack}), e.chr ? 32'd2 : 32'd1);
                    chk("ack_memaddr", 32'(last_addr), 32'(e.addr));
                    chk("ack_data", e.chr ? 32'(cromdata) : 32'(promdata), 32'(e.data));
                    if (e.chr) last_chr = e.data;
                    else       last_prg = e.data;
                end
            end
        end
    endtask

    task automatic rise_counter();
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (memreq && !prev) rises++;
            prev = memreq;
        end
    endtask

    task automatic prg_agent();
        int unsigned n;
        while (prg_script.size() > 0) begin
            @(negedge clk);
            promaddr = prg_script.pop_front();
            promreq  = 1'b1;
            n = 0;
            do begin @(negedge clk); n++; end while (!promack && n < 300);
            if (!promack) begin
                checks++;
                errors++;
                $display("FAIL prg_agent_timeout: no promack after %0d cycles, expected one", n);
            end
            promreq = 1'b0;
        end
    endtask

    task automatic chr_agent();
        int unsigned n;
        while (chr_script.size() > 0) begin
            @(negedge clk);
            cromaddr = chr_script.pop_front();
            cromreq  = 1'b1;
            n = 0;
            do begin @(negedge clk); n++; end while (!cromack && n < 300);
            if (!cromack) begin
                checks++;
                errors++;
                $display("FAIL chr_agent_timeout: no cromack after %0d cycles, expected one", n);
            end
            cromreq = 1'b0;
        end
    endtask

    task automatic wait_done(input string name);
        int unsigned n;
        n = 0;
        while (exp_q.size() > 0 && n < 400) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int unsigned n, r0, pa0, ca0;
        reset    = 1'b1;
        sel      = 1'b0;
        promaddr = '0;
        cromaddr = '0;
        promreq  = 1'b0;
        cromreq  = 1'b0;
        memrdata = '0;
        memack   = 1'b0;
        fork
            mem_model();
            monitor();
            rise_counter();
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_promack", 32'(promack), 32'd0);
        chk("rst_cromack", 32'(cromack), 32'd0);
        chk("rst_promdata", 32'(promdata), 32'd0);
        chk("rst_cromdata", 32'(cromdata), 32'd0);
        chk("rst_memreq", 32'(memreq), 32'd0);
        chk("rst_memaddr", 32'(memaddr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single PRG read, latency 3
        lat = 3;
        promaddr = 21'h1E005;
        promreq  = 1'b1;
        push_exp(1'b0, 21'h1E005, 8'hA5);
        r0 = rises;
        n  = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                chk("t1_memaddr", 32'(memaddr), 32'h01E005);
                chk("t1_memreq", 32'(memreq), 32'd1);
                chk("t1_busy", 32'(busy), 32'd1);
            end
        end while (!promack && n < 50);
        chk("t1_req_to_ack", n, 32'd5);
        repeat (20) @(negedge clk);
        chk("t1_single_memreq", rises - r0, 32'd1);
        chk("t1_promdata_held", 32'(promdata), 32'hA5);
        promreq = 1'b0;
        repeat (2) @(negedge clk);

        // CHR priority with both ports re-requesting
        prg_script = '{21'h0ABCD, 21'h15555};
        chr_script = '{21'h00400, 21'h1F0F0, 21'h00A5A};
        push_exp(1'b1, 21'h00400, 8'hA0);
        push_exp(1'b0, 21'h0ABCD, 8'h6D);
        push_exp(1'b1, 21'h1F0F0, 8'h50);
        push_exp(1'b0, 21'h15555, 8'hF5);
        push_exp(1'b1, 21'h00A5A, 8'hFA);
        fork
            prg_agent();
            chr_agent();
            begin
                repeat (2) @(negedge clk);
                chk("t2_first_memaddr", 32'(memaddr), 32'h200400);
            end
        join
        wait_done("t2_all_acked");

        // Abandoned PRG request, latency 4
        lat = 4;
        pa0 = prg_acks;
        @(negedge clk);
        promaddr = 21'h00123;
        promreq  = 1'b1;
        push_exp(1'b0, 21'h00123, 8'h83);
        @(negedge clk);
        chk("t4_memreq_up", 32'(memreq), 32'd1);
        @(negedge clk);
        promreq = 1'b0;
        wait_done("t4_abandon_acked");
        repeat (5) @(negedge clk);
        chk("t4_one_ack", prg_acks - pa0, 32'd1);
        promaddr = 21'h00777;
        promreq  = 1'b1;
        push_exp(1'b0, 21'h00777, 8'hD7);
        @(negedge clk);
        chk("t4_new_memaddr", 32'(memaddr), 32'h000777);
        n = 0;
        while (exp_q.size() > 0 && n < 50) begin @(negedge clk); n++; end
        promreq = 1'b0;
        wait_done("t4_new_acked");

        // Spurious memack in IDLE
        pa0 = prg_acks;
        ca0 = chr_acks;
        mem_auto = 1'b0;
        man_data = 8'hFF;
        @(posedge clk);
        man_ack = 1'b1;
        @(posedge clk);
        man_ack = 1'b0;
        repeat (4) @(negedge clk);
        chk("t5_promdata_kept", 32'(promdata), 32'(last_prg));
        chk("t5_cromdata_kept", 32'(cromdata), 32'(last_chr));
        chk("t5_no_ack", (prg_acks - pa0) + (chr_acks - ca0), 32'd0);
        chk("t5_memreq_low", 32'(memreq), 32'd0);
        mem_auto = 1'b1;

        // Round-robin instance: strict alternation, then pointer favours CHR
        @(negedge clk);
        sel = 1'b1;
        lat = 2;
        pa0 = prg_acks;
        ca0 = chr_acks;
        for (int i = 1; i <= 4; i++) begin
            logic [20:0] pa, ca;
            pa = 21'(i * 16);
            ca = 21'(i * 16 + 1);
            prg_script.push_back(pa);
            chr_script.push_back(ca);
            push_exp(1'b0, pa, pa[7:0] ^ 8'hA0);
            push_exp(1'b1, ca, ca[7:0] ^ 8'hA0);
        end
        fork
            prg_agent();
            chr_agent();
        join
        wait_done("t3_all_acked");
        chk("t3_prg_acks", prg_acks - pa0, 32'd4);
        chk("t3_chr_acks", chr_acks - ca0, 32'd4);
        prg_script = '{21'h00050};
        chr_script = '{21'h00051};
        push_exp(1'b1, 21'h00051, 8'hF1);
        push_exp(1'b0, 21'h00050, 8'hF0);
        fork
            prg_agent();
            chr_agent();
        join
        wait_done("t3_rr_tie_acked");
        @(negedge clk);
        sel = 1'b0;

        // Reset in the middle of CHR_WAIT
        mem_auto = 1'b0;
        ca0 = chr_acks;
        @(negedge clk);
        cromaddr = 21'h00055;
        cromreq  = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_busy_before", 32'(busy), 32'd1);
        chk("t6_memaddr_before", 32'(memaddr), 32'h200055);
        reset = 1'b1;
        #1;
        chk("t6_memreq_async", 32'(memreq), 32'd0);
        chk("t6_busy_async", 32'(busy), 32'd0);
        chk("t6_cromack_async", 32'(cromack), 32'd0);
        chk("t6_memaddr_async", 32'(memaddr), 32'd0);
        @(negedge clk);
        cromreq = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        man_data = 8'h3C;
        @(posedge clk);
        @(posedge clk);
        man_ack = 1'b1;
        @(posedge clk);
        man_ack = 1'b0;
        repeat (4) @(negedge clk);
        chk("t6_late_memack_no_ack", chr_acks - ca0, 32'd0);
        chk("t6_cromdata_reset", 32'(cromdata), 32'd0);
        chk("t6_memreq_idle", 32'(memreq), 32'd0);
        mem_auto = 1'b1;
        lat = 2;
        chr_script = '{21'h00066};
        push_exp(1'b1, 21'h00066, 8'hC6);
        chr_agent();
        wait_done("t6_after_reset_acked");

        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
